// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the single register-file write port between the in-order pipeline
// writeback and an auxiliary long-latency unit. Auxiliary results wait in a
// small in-order queue and drain into cycles the pipeline leaves free.
// Generates a RAW stall toward ID and a one-cycle starvation stall toward WB.
module rf_write_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pipe_we,
  input  logic [4:0]              pipe_addr,
  input  logic [31:0]             pipe_data,
  input  logic                    aux_valid,
  output logic                    aux_ready,
  input  logic [4:0]              aux_addr,
  input  logic [31:0]             aux_data,
  input  logic [4:0]              rs_addr,
  input  logic [4:0]              rt_addr,
  output logic                    raw_stall,
  output logic                    pipe_stall,
  output logic [4:0]              wd_addr,
  output logic [31:0]             wd_data,
  output logic                    rd_w_enable,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);
  localparam logic [3:0]  LIMIT_W = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_QUEUE
  } src_e;

  // Queue storage; an entry is live only while its valid bit is set.
  logic [4:0]       q_addr [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW:0]      count;
  logic [3:0]       starve_cnt;

  logic             head_occ;
  logic             head_valid;
  logic             pipe_req;
  logic             push;
  logic             pop;
  src_e             src;
  logic [3:0]       starve_nxt;
  logic             starve_hit;

  assign fifo_count = count;
  assign aux_ready  = (count < DEPTH_W);

  // Write-port arbitration: stolen slot, then pipeline, then queue head.
  always_comb begin
    head_occ   = (count != '0);
    head_valid = head_occ && q_valid[head];
    // pipe_we is ignored during a stolen slot (pipeline is re-presenting)
    // and while reset is held so the strobe stays low.
    pipe_req   = rst_n && !pipe_stall && pipe_we && (pipe_addr != '0);
    src        = SRC_NONE;
    if (pipe_stall && head_valid) begin
      src = SRC_QUEUE;
    end else if (pipe_req) begin
      src = SRC_PIPE;
    end else if (head_valid) begin
      src = SRC_QUEUE;
    end
    // A squashed head leaves silently even when the pipeline owns the port.
    pop  = head_occ && ((src == SRC_QUEUE) || !q_valid[head]);
    push = aux_valid && aux_ready && (aux_addr != '0);
  end

  // Drive the register-file port from the granted source.
  always_comb begin
    rd_w_enable = 1'b0;
    wd_addr     = '0;
    wd_data     = '0;
    case (src)
      SRC_PIPE: begin
        rd_w_enable = 1'b1;
        wd_addr     = pipe_addr;
        wd_data     = pipe_data;
      end
      SRC_QUEUE: begin
        rd_w_enable = 1'b1;
        wd_addr     = q_addr[head];
        wd_data     = q_data[head];
      end
      default: begin
        rd_w_enable = 1'b0;
      end
    endcase
  end

  // RAW detect against valid resident entries only.
  always_comb begin
    raw_stall = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (q_valid[i] && (rs_addr != '0) && (q_addr[i] == rs_addr)) begin
        raw_stall = 1'b1;
      end
      if (q_valid[i] && (rt_addr != '0) && (q_addr[i] == rt_addr)) begin
        raw_stall = 1'b1;
      end
    end
  end

  // Next starvation count: cleared by a head grant, bumped when the
  // pipeline wins while a valid head is waiting.
  always_comb begin
    starve_nxt = starve_cnt;
    if (src == SRC_QUEUE) begin
      starve_nxt = '0;
    end else if ((src == SRC_PIPE) && head_valid) begin
      starve_nxt = starve_cnt + 4'd1;
    end
    starve_hit = (starve_nxt == LIMIT_W);
  end

  // Starvation counter and the one-cycle stolen-slot request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end else begin
      pipe_stall <= starve_hit;
      starve_cnt <= starve_hit ? 4'd0 : starve_nxt;
    end
  end

  // Payload storage; liveness is tracked separately by q_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= aux_addr;
      q_data[tail] <= aux_data;
    end
  end

  // Pointers, occupancy and valid bits. The WAW squash only touches entries
  // already valid, so the slot being pushed this cycle is never cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      q_valid <= '0;
    end else begin
      if (src == SRC_PIPE) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (q_valid[i] && (q_addr[i] == pipe_addr)) begin
            q_valid[i] <= 1'b0;
          end
        end
      end
      if (pop) begin
        q_valid[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      if (push) begin
        q_valid[tail] <= 1'b1;
        tail          <= tail + PW'(1);
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Occupancy never exceeds capacity and nothing is popped from an empty queue.
  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_W);
  a_pop_nonempty : assert property (@(posedge clk) disable iff (!rst_n) pop |-> head_occ);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a queue-based reference model
// predicts each cycle's status and writes; a monitor compares them.
module tb_rf_write_arbiter;

  localparam int unsigned DEPTH        = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_addr = '0;
  logic [31:0] pipe_data = '0;
  logic        aux_valid = 1'b0;
  logic        aux_ready;
  logic [4:0]  aux_addr = '0;
  logic [31:0] aux_data = '0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic        raw_stall;
  logic        pipe_stall;
  logic [4:0]  wd_addr;
  logic [31:0] wd_data;
  logic        rd_w_enable;
  logic [1:0]  fifo_count;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .raw_stall(raw_stall), .pipe_stall(pipe_stall),
    .wd_addr(wd_addr), .wd_data(wd_data), .rd_w_enable(rd_w_enable), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] addr; logic [31:0] data; bit ok; } ent_t;
  typedef struct { logic [4:0] addr; logic [31:0] data; } wr_t;
  typedef struct { bit we; bit raw; bit stall; bit ready; int unsigned cnt; bit in_rst; } st_t;

  ent_t        mq[$];
  wr_t         wr_q[$];
  st_t         st_q[$];
  bit          m_stall;
  int unsigned m_starve;
  int unsigned checks;
  int unsigned passed;
  logic        last_we;
  logic [4:0]  last_pa;
  logic [31:0] last_pd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One functional cycle: drive inputs, predict outputs, advance the model.
  task automatic cycle(input bit we, input logic [4:0] pa, input logic [31:0] pd,
                       input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic [4:0] rs, input logic [4:0] rt);
    st_t s;
    bit  hv, wq, wp, do_pop;
    @(negedge clk);
    if (m_stall) begin
      we = last_we; pa = last_pa; pd = last_pd;
    end
    rst_n = 1'b1;
    pipe_we = we; pipe_addr = pa; pipe_data = pd;
    aux_valid = av; aux_addr = aa; aux_data = ad;
    rs_addr = rs; rt_addr = rt;
    last_we = we; last_pa = pa; last_pd = pd;

    s.in_rst = 1'b0;
    s.cnt    = mq.size();
    s.ready  = (mq.size() < DEPTH);
    s.stall  = m_stall;
    s.raw    = 1'b0;
    foreach (mq[i])
      if (mq[i].ok && ((rs != 0 && mq[i].addr == rs) || (rt != 0 && mq[i].addr == rt)))
        s.raw = 1'b1;
    hv = (mq.size() > 0) && mq[0].ok;
    wq = 1'b0; wp = 1'b0;
    if (m_stall) wq = hv;
    else if (we && pa != 0) wp = 1'b1;
    else wq = hv;
    s.we = wq || wp;
    if (wq) wr_q.push_back('{mq[0].addr, mq[0].data});
    if (wp) wr_q.push_back('{pa, pd});
    st_q.push_back(s);

    do_pop = (mq.size() > 0) && (wq || !hv);
    if (wp) foreach (mq[i]) if (mq[i].addr == pa) mq[i].ok = 1'b0;
    if (do_pop) void'(mq.pop_front());
    if (wq) m_starve = 0;
    else if (wp && hv) m_starve++;
    if (m_starve == STARVE_LIMIT) begin
      m_stall = 1'b1; m_starve = 0;
    end else begin
      m_stall = 1'b0;
    end
    if (av && s.ready && aa != 0) mq.push_back('{aa, ad, 1'b1});
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  // Reset cycles with busy inputs: everything must read as cleared.
  task automatic reset_cycles(input int unsigned n);
    st_t s;
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      rst_n = 1'b0;
      pipe_we = 1'b1; pipe_addr = 5'd11; pipe_data = 32'hDEAD_BEEF;
      aux_valid = 1'b1; aux_addr = 5'd12; aux_data = 32'h1234_5678;
      rs_addr = 5'd11; rt_addr = 5'd12;
      s = '{we: 1'b0, raw: 1'b0, stall: 1'b0, ready: 1'b1, cnt: 0, in_rst: 1'b1};
      st_q.push_back(s);
      mq.delete();
      m_stall = 1'b0; m_starve = 0;
      last_we = 1'b0; last_pa = '0; last_pd = '0;
    end
  endtask

  // Monitor: compares status every cycle and write payloads whenever the DUT writes.
  initial begin
    st_t s;
    wr_t w;
    forever begin
      @(negedge clk);
      #3;
      if (st_q.size() != 0) begin
        s = st_q.pop_front();
        chk("fifo_count", 32'(fifo_count), s.cnt);
        chk("aux_ready", 32'(aux_ready), 32'(s.ready));
        chk("raw_stall", 32'(raw_stall), 32'(s.raw));
        chk("pipe_stall", 32'(pipe_stall), 32'(s.stall));
        chk("rd_w_enable", 32'(rd_w_enable), 32'(s.we));
        if (s.in_rst) begin
          chk("wd_addr_rst", 32'(wd_addr), 32'd0);
          chk("wd_data_rst", wd_data, 32'd0);
        end
        if (rd_w_enable) begin
          if (wr_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_write: wd_addr=%0d wd_data=0x%0h, no write required", wd_addr, wd_data);
          end else begin
            w = wr_q.pop_front();
            chk("wd_addr", 32'(wd_addr), 32'(w.addr));
            chk("wd_data", wd_data, w.data);
          end
        end else if (s.we && wr_q.size() != 0) begin
          void'(wr_q.pop_front());
        end
      end
    end
  end

  initial begin
    checks = 0; passed = 0;
    m_stall = 1'b0; m_starve = 0;
    last_we = 1'b0; last_pa = '0; last_pd = '0;
    reset_cycles(3);

    // Idle pipe: queued entry written the following cycle.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA5A5_A5A5, 5'd0, 5'd0);
    idle(2);

    // Fill with 3 and 4 under continuous writeback; slots get stolen.
    cycle(1'b1, 5'd16, 32'h100, 1'b1, 5'd3, 32'h33, 5'd0, 5'd0);
    cycle(1'b1, 5'd17, 32'h101, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0);
    cycle(1'b1, 5'd18, 32'h102, 1'b1, 5'd6, 32'h66, 5'd0, 5'd0);
    for (int unsigned k = 0; k < 12; k++)
      cycle(1'b1, 5'(19 + k), 32'h200 + k, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle(2);

    // RAW detection on rs, rt, and register 0.
    cycle(1'b1, 5'd20, 32'h300, 1'b1, 5'd5, 32'h55, 5'd5, 5'd0);
    cycle(1'b1, 5'd21, 32'h301, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    cycle(1'b1, 5'd22, 32'h302, 1'b0, 5'd0, 32'd0, 5'd0, 5'd5);
    cycle(1'b1, 5'd23, 32'h303, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle(2);

    // WAW squash: pipeline overwrites queued register 9.
    cycle(1'b1, 5'd20, 32'h400, 1'b1, 5'd9, 32'h1, 5'd0, 5'd0);
    cycle(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    idle(2);

    // Register 0 from either source produces nothing.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    cycle(1'b1, 5'd0, 32'hCAFE, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle(1);

    // Reset with two queued entries; nothing stale afterwards.
    cycle(1'b1, 5'd20, 32'h500, 1'b1, 5'd11, 32'hB1, 5'd0, 5'd0);
    cycle(1'b1, 5'd21, 32'h501, 1'b1, 5'd12, 32'hB2, 5'd0, 5'd0);
    reset_cycles(2);
    idle(4);

    // Randomized traffic with occasional resets.
    for (int unsigned k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) == 0) reset_cycles(1 + $urandom_range(0, 1));
      else cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 9)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 9)), $urandom,
                 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
    end

    idle(6);
    @(negedge clk);
    #4;
    chk("writes_drained", wr_q.size(), 32'd0);
    chk("status_drained", st_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
